vram_arbiter: RTL and testbench

- Shares one single-port synchronous video RAM between the CRTC display fetch and the Z80 CPU.
- The CRTC gets absolute priority: each fetch request owns the RAM port for one cycle.
- The CPU uses the idle cycles and is held off via WAIT_n until its read data is captured or its write is committed.
- Sits between tv80e/CRTC address decode and the VRAM spram instance.

---
 rtl/vram_arb_pkg.sv | 23 ++
 rtl/vram_wbuf.sv | 42 ++++
 rtl/vram_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_vram_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// Shared types for the VRAM arbiter: FSM states, pipeline tags and the
// fixed display fetch latency.
package vram_arb_pkg;

    // CPU access sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CAPT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    // Owner of the access travelling down the RAM pipeline
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_DISP = 2'd1,
        TAG_CPU  = 2'd2
    } arb_tag_e;

    // crtc_req in cycle n -> crtc_valid in cycle n + DISP_LATENCY
    localparam int DISP_LATENCY = 3;

endpackage

// File: rtl/vram_wbuf.sv
// One-entry posted write buffer for the VRAM arbiter. Used only when
// VRAM_POSTED_WR_EN is defined. Load and drain are never requested in the
// same cycle: load requires an empty buffer, drain a full one.
module vram_wbuf #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic [DATA_W-1:0] load_data_i,
    input  logic              drain_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;

    // Capture a posted write, release the entry once it reaches the RAM port
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            addr_q  <= load_addr_i;
            data_q  <= load_data_i;
        end else if (drain_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign addr_o  = addr_q;
    assign data_o  = data_q;

endmodule

// File: rtl/vram_arbiter.sv
// VRAM arbiter: shares one single-port synchronous RAM between the CRTC
// display fetch (absolute priority, fixed 3-cycle latency) and the Z80,
// which is stalled through cpu_wait_n until its access completes.
// Optional: define VRAM_POSTED_WR_EN for a one-entry posted write buffer
// (vram_wbuf) with read forwarding.
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              crtc_req,
    input  logic [ADDR_W-1:0] crtc_addr,
    output logic [DATA_W-1:0] crtc_data,
    output logic              crtc_valid,
    input  logic              cpu_cs,
    input  logic              cpu_rd_n,
    input  logic              cpu_wr_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    output logic [DATA_W-1:0] cpu_dout,
    output logic              cpu_wait_n,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_we,
    output logic [DATA_W-1:0] vram_wdata,
    input  logic [DATA_W-1:0] vram_rdata
);

    localparam int TAG_STAGES = DISP_LATENCY - 1;

    logic cpu_stb;
    logic cpu_wr;
    logic cpu_issue;

    arb_state_e        state_q;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    arb_tag_e          tag_q [TAG_STAGES];
    logic [DATA_W-1:0] crtc_data_q;
    logic              crtc_valid_q;
    logic [DATA_W-1:0] cpu_dout_q;

    // Write wins when both strobes are low
    assign cpu_stb = cpu_cs & (~cpu_rd_n | ~cpu_wr_n);
    assign cpu_wr  = cpu_cs & ~cpu_wr_n;

`ifdef VRAM_POSTED_WR_EN
    logic              cpu_rd_only;
    logic              wb_valid;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic              wb_hit;
    logic              wb_fwd;
    logic              post_accept;
    logic              wb_drain;

    assign cpu_rd_only = cpu_stb & ~cpu_wr;
    assign wb_hit      = wb_valid && (wb_addr == cpu_addr);
    // Writes never occupy the port directly; they are parked in the buffer
    assign post_accept = (state_q == IDLE) && cpu_wr && !wb_valid;
    assign wb_fwd      = (state_q == IDLE) && cpu_rd_only && wb_hit;
    assign cpu_issue   = (state_q == IDLE) && cpu_rd_only && !wb_hit && !crtc_req;
    assign wb_drain    = wb_valid && !crtc_req && !cpu_issue;
    assign cpu_wait_n  = ~(reset_n && cpu_stb && (state_q != DONE) && !post_accept);

    vram_wbuf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wbuf (
        .clk         (clk),
        .reset_n     (reset_n),
        .load_i      (post_accept),
        .load_addr_i (cpu_addr),
        .load_data_i (cpu_din),
        .drain_i     (wb_drain),
        .valid_o     (wb_valid),
        .addr_o      (wb_addr),
        .data_o      (wb_data)
    );
`else
    assign cpu_issue  = (state_q == IDLE) && cpu_stb && !crtc_req;
    assign cpu_wait_n = ~(reset_n && cpu_stb && (state_q != DONE));
`endif

    // RAM port mux (display first, then CPU, then buffer drain) plus tag pipeline
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            for (int i = 0; i < TAG_STAGES; i++) begin
                tag_q[i] <= TAG_NONE;
            end
        end else begin
            for (int i = 1; i < TAG_STAGES; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            if (crtc_req) begin
                addr_q   <= crtc_addr;
                we_q     <= 1'b0;
                tag_q[0] <= TAG_DISP;
            end else if (cpu_issue) begin
                addr_q   <= cpu_addr;
                wdata_q  <= cpu_din;
                we_q     <= cpu_wr;
                tag_q[0] <= TAG_CPU;
            end
`ifdef VRAM_POSTED_WR_EN
            else if (wb_drain) begin
                addr_q   <= wb_addr;
                wdata_q  <= wb_data;
                we_q     <= 1'b1;
                tag_q[0] <= TAG_NONE;
            end
`endif
            else begin
                we_q     <= 1'b0;
                tag_q[0] <= TAG_NONE;
            end
        end
    end

    // Display return: capture RAM data whose tag marks it as a fetch
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            crtc_data_q  <= '0;
            crtc_valid_q <= 1'b0;
        end else begin
            crtc_valid_q <= (tag_q[TAG_STAGES-1] == TAG_DISP);
            if (tag_q[TAG_STAGES-1] == TAG_DISP) begin
                crtc_data_q <= vram_rdata;
            end
        end
    end

    // CPU sequencer: one RAM access per Z80 bus cycle, held in DONE until strobe drops
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cpu_dout_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
`ifdef VRAM_POSTED_WR_EN
                    if (post_accept) begin
                        state_q <= DONE;
                    end else if (wb_fwd) begin
                        cpu_dout_q <= wb_data;
                        state_q    <= DONE;
                    end else if (cpu_issue) begin
                        state_q <= ISSUE;
                    end
`else
                    if (cpu_issue) begin
                        state_q <= ISSUE;
                    end
`endif
                end
                ISSUE: begin
                    if (we_q) begin
                        state_q <= cpu_stb ? DONE : IDLE;
                    end else begin
                        state_q <= CAPT;
                    end
                end
                CAPT: begin
                    cpu_dout_q <= vram_rdata;
                    state_q    <= cpu_stb ? DONE : IDLE;
                end
                DONE: begin
                    if (!cpu_stb) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign vram_addr  = addr_q;
    // Gated so a write caught mid-flight by reset never reaches the RAM
    assign vram_we    = we_q & reset_n;
    assign vram_wdata = wdata_q;
    assign crtc_data  = crtc_data_q;
    assign crtc_valid = crtc_valid_q;
    assign cpu_dout   = cpu_dout_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: stimulus pushes expected display
// returns, RAM writes and CPU completions; independent monitors pop them.
module tb_vram_arbiter;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              crtc_req;
    logic [ADDR_W-1:0] crtc_addr;
    logic [DATA_W-1:0] crtc_data;
    logic              crtc_valid;
    logic              cpu_cs;
    logic              cpu_rd_n;
    logic              cpu_wr_n;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_din;
    logic [DATA_W-1:0] cpu_dout;
    logic              cpu_wait_n;
    logic [ADDR_W-1:0] vram_addr;
    logic              vram_we;
    logic [DATA_W-1:0] vram_wdata;
    logic [DATA_W-1:0] vram_rdata;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .crtc_req   (crtc_req),
        .crtc_addr  (crtc_addr),
        .crtc_data  (crtc_data),
        .crtc_valid (crtc_valid),
        .cpu_cs     (cpu_cs),
        .cpu_rd_n   (cpu_rd_n),
        .cpu_wr_n   (cpu_wr_n),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cpu_dout   (cpu_dout),
        .cpu_wait_n (cpu_wait_n),
        .vram_addr  (vram_addr),
        .vram_we    (vram_we),
        .vram_wdata (vram_wdata),
        .vram_rdata (vram_rdata)
    );

    // Behavioural single-port synchronous RAM
    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] ram_rd;
    initial begin : ram_model
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 8'(i) ^ 8'h3C;
        mem[14'h0123] = 8'h5A;
        mem[14'h0400] = 8'hC3;
        mem[14'h0010] = 8'hE7;
        mem[14'h0555] = 8'h96;
        mem[14'h0200] = 8'h11;
        mem[14'h0201] = 8'h22;
        mem[14'h0202] = 8'h33;
        mem[14'h0203] = 8'h44;
        mem[14'h0ABC] = 8'h01;
        mem[14'h1FFF] = 8'h00;
        vram_rdata = '0;
        forever begin
            @(posedge clk);
            ram_rd = mem[vram_addr];
            if (vram_we) mem[vram_addr] = vram_wdata;
            vram_rdata <= ram_rd;
        end
    end

    typedef struct { int cyc; logic [7:0] data; } crtc_exp_t;
    typedef struct { int cyc; logic [13:0] addr; logic [7:0] data; } wr_exp_t;
    typedef struct { int waits; logic is_rd; logic [7:0] data; } cpu_exp_t;

    crtc_exp_t crtc_q[$];
    wr_exp_t   wr_q[$];
    cpu_exp_t  cpu_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: 0x%0h (cycle %0d)", name, act, cyc);
        end
    endtask

    task automatic exp_crtc(input int c, input logic [7:0] d);
        crtc_exp_t e;
        e.cyc = c; e.data = d;
        crtc_q.push_back(e);
    endtask

    task automatic exp_wr(input int c, input logic [13:0] a, input logic [7:0] d);
        wr_exp_t e;
        e.cyc = c; e.addr = a; e.data = d;
        wr_q.push_back(e);
    endtask

    task automatic exp_cpu(input int w, input logic r, input logic [7:0] d);
        cpu_exp_t e;
        e.waits = w; e.is_rd = r; e.data = d;
        cpu_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Display monitor
    crtc_exp_t crtc_e;
    always @(negedge clk) begin
        if (reset_n && crtc_valid) begin
            if (crtc_q.size() == 0) begin
                check("crtc_valid_unexpected", 32'd1, 32'd0);
            end else begin
                crtc_e = crtc_q.pop_front();
                check("crtc_cycle", cyc, crtc_e.cyc);
                check("crtc_data", {24'd0, crtc_data}, {24'd0, crtc_e.data});
            end
        end
    end

    // RAM write monitor
    wr_exp_t wr_e;
    always @(negedge clk) begin
        if (vram_we) begin
            if (wr_q.size() == 0) begin
                check("vram_we_unexpected", {18'd0, vram_addr}, 32'hFFFF);
            end else begin
                wr_e = wr_q.pop_front();
                check("wr_cycle", cyc, wr_e.cyc);
                check("wr_addr", {18'd0, vram_addr}, {18'd0, wr_e.addr});
                check("wr_data", {24'd0, vram_wdata}, {24'd0, wr_e.data});
            end
        end
    end

    // CPU bus-cycle monitor: counts stall cycles, checks completion and no re-stall
    int       mon_waits = 0;
    bit       mon_done  = 0;
    cpu_exp_t cpu_e;
    always @(negedge clk) begin
        if (!reset_n || !(cpu_cs && (!cpu_rd_n || !cpu_wr_n))) begin
            mon_waits = 0;
            mon_done  = 0;
        end else if (!mon_done) begin
            if (!cpu_wait_n) begin
                mon_waits++;
                if (mon_waits > 50) begin
                    check("cpu_wait_timeout", 32'd0, 32'd1);
                    mon_done = 1;
                end
            end else begin
                mon_done = 1;
                if (cpu_q.size() == 0) begin
                    check("cpu_unexpected_completion", 32'd1, 32'd0);
                end else begin
                    cpu_e = cpu_q.pop_front();
                    check("cpu_wait_cycles", mon_waits, cpu_e.waits);
                    if (cpu_e.is_rd) check("cpu_dout", {24'd0, cpu_dout}, {24'd0, cpu_e.data});
                end
            end
        end else if (!cpu_wait_n) begin
            check("cpu_restall", 32'd0, 32'd1);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_vram_addr"},  {18'd0, vram_addr}, 32'd0);
        check({tag, "_vram_we"},    {31'd0, vram_we}, 32'd0);
        check({tag, "_vram_wdata"}, {24'd0, vram_wdata}, 32'd0);
        check({tag, "_crtc_data"},  {24'd0, crtc_data}, 32'd0);
        check({tag, "_crtc_valid"}, {31'd0, crtc_valid}, 32'd0);
        check({tag, "_cpu_dout"},   {24'd0, cpu_dout}, 32'd0);
        check({tag, "_cpu_wait_n"}, {31'd0, cpu_wait_n}, 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        bit wait_ok;
        reset_n   = 1'b0;
        crtc_req  = 1'b0;
        crtc_addr = '0;
        cpu_cs    = 1'b0;
        cpu_rd_n  = 1'b1;
        cpu_wr_n  = 1'b1;
        cpu_addr  = '0;
        cpu_din   = '0;

        // Reset held two cycles with the CPU idle, then released
        tick();
        check_reset_outputs("rst1");
        tick();
        check_reset_outputs("rst2");
        reset_n = 1'b1;
        tick();
        check_reset_outputs("post_rst");

        // Single display fetch of 0x0123
        tick();
        crtc_req  = 1'b1;
        crtc_addr = 14'h0123;
        exp_crtc(cyc + 3, 8'h5A);
        tick();
        crtc_req = 1'b0;
        wait_ok = 1;
        repeat (4) begin
            tick();
            if (!cpu_wait_n) wait_ok = 0;
        end
        check("disp_wait_n_untouched", {31'd0, wait_ok}, 32'd1);

        // CPU read of 0x0400 held ten cycles: 3 stall cycles, one access
        tick();
        cpu_cs   = 1'b1;
        cpu_rd_n = 1'b0;
        cpu_addr = 14'h0400;
        exp_cpu(3, 1'b1, 8'hC3);
        repeat (10) tick();
        cpu_cs   = 1'b0;
        cpu_rd_n = 1'b1;
        tick();

        // CPU write 0x1FFF=0xA5 colliding with a display fetch
        tick();
        cpu_cs    = 1'b1;
        cpu_wr_n  = 1'b0;
        cpu_addr  = 14'h1FFF;
        cpu_din   = 8'hA5;
        crtc_req  = 1'b1;
        crtc_addr = 14'h0010;
        exp_crtc(cyc + 3, 8'hE7);
        exp_wr(cyc + 2, 14'h1FFF, 8'hA5);
`ifdef VRAM_POSTED_WR_EN
        exp_cpu(0, 1'b0, 8'h00);
`else
        exp_cpu(3, 1'b0, 8'h00);
`endif
        tick();
        crtc_req = 1'b0;
        repeat (3) tick();
        cpu_cs   = 1'b0;
        cpu_wr_n = 1'b1;
        repeat (2) tick();
        check("mem_1fff_written", {24'd0, mem[14'h1FFF]}, 32'h0000_00A5);

        // CPU read of 0x0555 with display fetches every other cycle
        tick();
        cpu_cs   = 1'b1;
        cpu_rd_n = 1'b0;
        cpu_addr = 14'h0555;
        exp_cpu(4, 1'b1, 8'h96);
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) begin
                crtc_req  = 1'b1;
                crtc_addr = 14'h0200 + 14'(k / 2);
                exp_crtc(cyc + 3, 8'h11 * 8'(k / 2 + 1));
            end else begin
                crtc_req = 1'b0;
            end
            tick();
        end
        crtc_req = 1'b0;
        cpu_cs   = 1'b0;
        cpu_rd_n = 1'b1;
        repeat (3) tick();

`ifdef VRAM_POSTED_WR_EN
        // Posted write then immediate read of the same address while the
        // display keeps the port busy: read is forwarded from the buffer
        tick();
        cpu_cs    = 1'b1;
        cpu_wr_n  = 1'b0;
        cpu_addr  = 14'h0ABC;
        cpu_din   = 8'h77;
        crtc_req  = 1'b1;
        crtc_addr = 14'h0200;
        exp_crtc(cyc + 3, 8'h11);
        exp_cpu(0, 1'b0, 8'h00);
        tick();
        cpu_cs    = 1'b0;
        cpu_wr_n  = 1'b1;
        crtc_addr = 14'h0201;
        exp_crtc(cyc + 3, 8'h22);
        tick();
        cpu_cs    = 1'b1;
        cpu_rd_n  = 1'b0;
        crtc_addr = 14'h0202;
        exp_crtc(cyc + 3, 8'h33);
        exp_cpu(1, 1'b1, 8'h77);
        exp_wr(cyc + 2, 14'h0ABC, 8'h77);
        tick();
        crtc_req = 1'b0;
        repeat (2) tick();
        cpu_cs   = 1'b0;
        cpu_rd_n = 1'b1;
        repeat (3) tick();
        check("mem_0abc_drained", {24'd0, mem[14'h0ABC]}, 32'h0000_0077);
`else
        // Reset during ISSUE of a write: write abandoned, RAM unchanged
        tick();
        cpu_cs   = 1'b1;
        cpu_wr_n = 1'b0;
        cpu_addr = 14'h0ABC;
        cpu_din  = 8'h77;
        tick();
        reset_n  = 1'b0;
        cpu_cs   = 1'b0;
        cpu_wr_n = 1'b1;
        #1;
        check("rst_issue_we_now", {31'd0, vram_we}, 32'd0);
        tick();
        check("rst_issue_we_next", {31'd0, vram_we}, 32'd0);
        check("rst_issue_wait_n", {31'd0, cpu_wait_n}, 32'd1);
        reset_n = 1'b1;
        repeat (2) tick();
        check("mem_0abc_unchanged", {24'd0, mem[14'h0ABC]}, 32'h0000_0001);
        // FSM back in IDLE: a plain read takes the uncontended 3 stall cycles
        cpu_cs   = 1'b1;
        cpu_rd_n = 1'b0;
        cpu_addr = 14'h0ABC;
        exp_cpu(3, 1'b1, 8'h01);
        repeat (5) tick();
        cpu_cs   = 1'b0;
        cpu_rd_n = 1'b1;
        repeat (3) tick();
`endif

        repeat (4) tick();
        check("crtc_queue_drained", crtc_q.size(), 32'd0);
        check("wr_queue_drained",   wr_q.size(), 32'd0);
        check("cpu_queue_drained",  cpu_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
